// File: rtl/observer_arb_pkg.sv
// Shared state encoding and header-byte layout for the observer AXIS arbiter.
// Optional header beat enabled by defining OBSERVER_ARB_ID_HDR_EN.
package observer_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PASS = 2'd2
    } arb_state_t;

    // Header byte carries the source index in its low nibble, upper bits zero.
    localparam int HDR_IDX_W = 4;

    function automatic logic [7:0] hdr_byte(input logic [HDR_IDX_W-1:0] idx);
        return {{(8-HDR_IDX_W){1'b0}}, idx};
    endfunction

endpackage

// File: rtl/observer_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// Uses a double-width rotate followed by a lowest-bit priority encoder.
module observer_rr_pick #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           valid,
    output logic [IDW-1:0] idx
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IDW:0]   off;
    logic [IDW:0]   sum;

    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[N-1:0];
        off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) off = (IDW+1)'(k);
        end
        sum = {1'b0, ptr} + off;
        if (sum >= (IDW+1)'(N)) sum = sum - (IDW+1)'(N);
        valid = |req;
        idx   = sum[IDW-1:0];
    end

endmodule

// File: rtl/observer_axis_arbiter.sv
// Packet-atomic round-robin merge of N AXI-Stream byte sources into one stream.
// Define OBSERVER_ARB_ID_HDR_EN to prefix each packet with a source-index header beat.
module observer_axis_arbiter
    import observer_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [N-1:0]           i_en,
    input  logic [N*8-1:0]         i_tdata,
    input  logic [N-1:0]           i_tlast,
    input  logic [N-1:0]           i_tvalid,
    output logic [N-1:0]           o_tready,
    output logic [7:0]             o_tdata,
    output logic                   o_tlast,
    output logic                   o_tvalid,
    input  logic                   i_tready,
    output logic [$clog2(N)-1:0]   o_grant,
    output logic                   o_busy
);

    localparam int IDW = $clog2(N);

    arb_state_t     state_q, state_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [N-1:0]   req;
    logic           pick_valid;
    logic [IDW-1:0] pick_idx;

    assign req = i_tvalid & i_en;

    observer_rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        o_tdata  = '0;
        o_tlast  = 1'b0;
        o_tvalid = 1'b0;
        o_tready = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
`ifdef OBSERVER_ARB_ID_HDR_EN
                    state_d = ST_HDR;
`else
                    state_d = ST_PASS;
`endif
                end
            end
`ifdef OBSERVER_ARB_ID_HDR_EN
            ST_HDR: begin
                o_tvalid = 1'b1;
                o_tdata  = hdr_byte(HDR_IDX_W'(grant_q));
                if (i_tready) state_d = ST_PASS;
            end
`endif
            ST_PASS: begin
                // Grant stays put until the tlast beat, whatever i_en does.
                o_tvalid          = i_tvalid[grant_q];
                o_tlast           = i_tlast[grant_q];
                o_tdata           = i_tdata[8*int'(grant_q) +: 8];
                o_tready[grant_q] = i_tready;
                if (o_tvalid && i_tready && o_tlast) begin
                    state_d = ST_IDLE;
                    ptr_d   = (grant_q == IDW'(N - 1)) ? '0 : grant_q + IDW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_grant = grant_q;
    assign o_busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_observer_axis_arbiter.sv
// Randomized scoreboard bench for observer_axis_arbiter against a packet-level model.
// Honours OBSERVER_ARB_ID_HDR_EN by expecting a header beat before each packet.
module tb_observer_axis_arbiter;

    localparam int N   = 4;
    localparam int IDW = $clog2(N);

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   i_en = '0;
    logic [N*8-1:0] i_tdata = '0;
    logic [N-1:0]   i_tlast = '0;
    logic [N-1:0]   i_tvalid = '0;
    logic [N-1:0]   o_tready;
    logic [7:0]     o_tdata;
    logic           o_tlast;
    logic           o_tvalid;
    logic           i_tready = 1'b0;
    logic [IDW-1:0] o_grant;
    logic           o_busy;

    observer_axis_arbiter #(.N(N)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_en     (i_en),
        .i_tdata  (i_tdata),
        .i_tlast  (i_tlast),
        .i_tvalid (i_tvalid),
        .o_tready (o_tready),
        .o_tdata  (o_tdata),
        .o_tlast  (o_tlast),
        .o_tvalid (o_tvalid),
        .i_tready (i_tready),
        .o_grant  (o_grant),
        .o_busy   (o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int src;
        int data;
        bit last;
    } beat_t;

    beat_t        exp_q[$];
    byte unsigned sq_data[N][$];
    bit           sq_last[N][$];

    int           checks = 0;
    int           errors = 0;
    int           m_ptr = 0;
    int           m_grant = 0;
    int           m_beats = 0;
    bit           m_busy = 1'b0;
    bit           prev_stall = 1'b0;
    logic [7:0]   prev_data = '0;
    logic         prev_last = 1'b0;
    logic [N-1:0] base_en = '1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endtask

    task automatic gen_packets(input int cnt, input int lmin, input int lmax);
        for (int k = 0; k < N; k++) begin
            for (int p = 0; p < cnt; p++) begin
                int len = $urandom_range(lmax, lmin);
                for (int b = 0; b < len; b++) begin
                    sq_data[k].push_back(8'($urandom));
                    sq_last[k].push_back(b == len - 1);
                end
            end
        end
    endtask

    // Packet-level reference: arbitration decided from the rotation rule alone.
    task automatic model_step();
        logic [N-1:0] req;
        int w;
        if (!m_busy) begin
            chk("idle_busy", int'(o_busy), 0);
            chk("idle_tvalid", int'(o_tvalid), 0);
            chk("idle_tready", int'(o_tready), 0);
            req = i_tvalid & i_en;
            if (req != '0) begin
                w = -1;
                for (int j = 0; j < N; j++) begin
                    int c = (m_ptr + j) % N;
                    if (w < 0 && req[c]) w = c;
                end
                m_busy  = 1'b1;
                m_grant = w;
                m_ptr   = (w + 1) % N;
                m_beats = 0;
`ifdef OBSERVER_ARB_ID_HDR_EN
                exp_q.push_back('{src: w, data: w, last: 1'b0});
`endif
                for (int b = 0; b < sq_data[w].size(); b++) begin
                    exp_q.push_back('{src: w, data: int'(sq_data[w][b]), last: sq_last[w][b]});
                    if (sq_last[w][b]) break;
                end
            end
        end else begin
            chk("busy", int'(o_busy), 1);
            chk("grant", int'(o_grant), m_grant);
        end
    endtask

    task automatic monitor_step();
        beat_t e;
        if (m_busy) chk("tready_mask", int'(o_tready & ~(N'(1) << m_grant)), 0);
        if (prev_stall) begin
            chk("stall_valid", int'(o_tvalid), 1);
            chk("stall_data", int'(o_tdata), int'(prev_data));
            chk("stall_last", int'(o_tlast), int'(prev_last));
        end
        if (o_tvalid && i_tready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("data", int'(o_tdata), e.data);
                chk("last", int'(o_tlast), int'(e.last));
                chk("beat_src", int'(o_grant), e.src);
                m_beats++;
                if (e.last) m_busy = 1'b0;
            end
        end
        prev_stall = o_tvalid && !i_tready;
        prev_data  = o_tdata;
        prev_last  = o_tlast;
    endtask

    task automatic drive(input logic [N-1:0] fire, input bit force_all);
        for (int k = 0; k < N; k++) begin
            bit hold;
            if (fire[k]) begin
                void'(sq_data[k].pop_front());
                void'(sq_last[k].pop_front());
            end
            hold = i_tvalid[k] && !fire[k];
            if (!hold)
                i_tvalid[k] = (sq_data[k].size() > 0) &&
                              (force_all || $urandom_range(9, 0) < 7);
            if (i_tvalid[k]) begin
                i_tdata[8*k +: 8] = sq_data[k][0];
                i_tlast[k]        = sq_last[k][0];
            end else begin
                i_tdata[8*k +: 8] = 8'($urandom);
                i_tlast[k]        = 1'($urandom);
            end
            i_en[k] = base_en[k] && (force_all || $urandom_range(9, 0) < 8);
        end
        i_tready = force_all || ($urandom_range(9, 0) < 7);
    endtask

    task automatic step(input bit force_all);
        logic [N-1:0] fire;
        @(negedge clk);
        model_step();
        monitor_step();
        fire = i_tvalid & o_tready;
        @(posedge clk);
        #1;
        drive(fire, force_all);
    endtask

    function automatic bit drained();
        bit d = !m_busy && exp_q.size() == 0;
        for (int k = 0; k < N; k++)
            if (base_en[k] && sq_data[k].size() > 0) d = 1'b0;
        return d;
    endfunction

    task automatic run_phase(input string name, input int budget);
        int n = 0;
        while (!drained() && n < budget) begin
            step(1'b0);
            n++;
        end
        if (!drained()) chk({name, "_timeout"}, 1, 0);
    endtask

    task automatic flush_sources();
        for (int k = 0; k < N; k++) begin
            sq_data[k].delete();
            sq_last[k].delete();
        end
        i_tvalid = '0;
    endtask

    initial begin
        int n;
        #12;
        chk("rst_tvalid", int'(o_tvalid), 0);
        chk("rst_tready", int'(o_tready), 0);
        chk("rst_grant", int'(o_grant), 0);
        chk("rst_busy", int'(o_busy), 0);

        gen_packets(10, 1, 5);
        base_en = '1;
        @(posedge clk);
        #1;
        drive('0, 1'b1);
        #1 rst_n = 1'b1;
        run_phase("all_en", 5000);

        // Source 2 masked off: its packets must never appear.
        gen_packets(6, 1, 4);
        base_en = 4'b1011;
        run_phase("masked", 5000);
        flush_sources();

        // Everything masked: arbiter must stay idle.
        gen_packets(3, 1, 3);
        base_en = '0;
        for (int i = 0; i < 30; i++) step(1'b0);
        base_en = '1;
        run_phase("unmask", 5000);

        // Reset in the middle of a source-3 packet.
        gen_packets(6, 4, 6);
        n = 0;
        while (!(m_busy && m_grant == 3 && m_beats > 0) && n < 3000) begin
            step(1'b0);
            n++;
        end
        chk("found_src3_pkt", int'(m_busy && m_grant == 3), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_tvalid", int'(o_tvalid), 0);
        chk("midrst_tready", int'(o_tready), 0);
        chk("midrst_grant", int'(o_grant), 0);
        chk("midrst_busy", int'(o_busy), 0);
        flush_sources();
        exp_q.delete();
        m_busy     = 1'b0;
        m_ptr      = 0;
        prev_stall = 1'b0;
        gen_packets(4, 1, 4);
        @(posedge clk);
        @(posedge clk);
        #1;
        drive('0, 1'b1);
        #1 rst_n = 1'b1;
        step(1'b0);
        chk("post_rst_pick", m_grant, 0);
        run_phase("post_rst", 5000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
